// File: rtl/pwl_activation_pipe_if.sv
// Handshake and configuration bundle for pwl_activation_pipe.
// The master side drives samples and table writes; the slave side is the activation unit.
interface pwl_activation_pipe_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_data,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pwl_activation_pipe.sv
// Pipelined, runtime-programmable piecewise-linear activation y = m[k]*x + c[k], sign-magnitude.
// Stages: segment select + capture of x/m/c, multiply, add/saturate into the output register.
module pwl_activation_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 27,
  parameter int NSEG  = 9,
  parameter int AW    = 4
) (
  input logic                  clk,
  input logic                  rst,
  pwl_activation_pipe_if.slave bus
);
  localparam int MW = WIDTH - 1;
  localparam int SW = $clog2(NSEG);
  localparam int BW = (NSEG > 2) ? $clog2(NSEG - 1) : 1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {MW{1'b1}}};
  localparam logic [MW-1:0]    MAG_SAT = '1;

  // Sign-magnitude to two's complement, one bit wider so -0 and +0 both map to zero.
  function automatic logic signed [WIDTH:0] sm_to_signed(input logic [WIDTH-1:0] v);
    logic signed [WIDTH:0] mag;
    mag = $signed({2'b00, v[MW-1:0]});
    return v[WIDTH-1] ? -mag : mag;
  endfunction

  logic [WIDTH-1:0] m_q  [NSEG];
  logic [WIDTH-1:0] c_q  [NSEG];
  logic [WIDTH-1:0] bp_q [NSEG-1];

  logic mc_addr_ok;
  logic bp_addr_ok;

  assign mc_addr_ok = int'(bus.cfg_addr) < NSEG;
  assign bp_addr_ok = int'(bus.cfg_addr) < (NSEG - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        m_q[i] <= ONE;
        c_q[i] <= '0;
      end
      for (int i = 0; i < NSEG - 1; i++) begin
        bp_q[i] <= MAX_POS;
      end
    end else if (bus.cfg_we) begin
      unique case (bus.cfg_sel)
        2'd0:    if (mc_addr_ok) m_q[bus.cfg_addr[SW-1:0]] <= bus.cfg_data;
        2'd1:    if (mc_addr_ok) c_q[bus.cfg_addr[SW-1:0]] <= bus.cfg_data;
        2'd2:    if (bp_addr_ok) bp_q[bus.cfg_addr[BW-1:0]] <= bus.cfg_data;
        default: ;
      endcase
    end
  end

  // Segment index is the number of breakpoints strictly below x, so a
  // non-monotonic table still yields a well-defined k.
  logic [NSEG-2:0] above;
  logic [SW-1:0]   seg_d;

  for (genvar gi = 0; gi < NSEG - 1; gi++) begin : g_cmp
    assign above[gi] = sm_to_signed(bus.in_data) > sm_to_signed(bp_q[gi]);
  end

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NSEG - 1; i++) begin
      seg_d = seg_d + SW'(above[i]);
    end
  end

  logic             s1_v_q;
  logic [WIDTH-1:0] s1_x_q;
  logic [WIDTH-1:0] s1_m_q;
  logic [WIDTH-1:0] s1_c_q;
  logic             s2_v_q;
  logic             s2_sign_q;
  logic [MW-1:0]    s2_mag_q;
  logic [WIDTH-1:0] s2_c_q;
  logic             out_v_q;
  logic [WIDTH-1:0] out_data_q;

  logic s3_free;
  logic s2_free;
  logic s2_adv;
  logic s1_free;
  logic s1_adv;
  logic in_ready;
  logic accept;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s3_free  = ~out_v_q | bus.out_ready;
  assign s2_free  = ~s2_v_q | s3_free;
  assign s2_adv   = s2_v_q & s3_free;
  assign s1_free  = ~s1_v_q | s2_free;
  assign s1_adv   = s1_v_q & s2_free;
  assign in_ready = ~bus.cfg_we & s1_free;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
    end else if (s1_free) begin
      s1_v_q <= accept;
    end
    if (accept) begin
      s1_x_q <= bus.in_data;
      s1_m_q <= m_q[seg_d];
      s1_c_q <= c_q[seg_d];
    end
  end

  logic [2*MW-1:0] prod_full;
  logic [2*MW-1:0] prod_shift;
  logic            s2_sign_d;
  logic [MW-1:0]   s2_mag_d;

  always_comb begin
    prod_full  = {{MW{1'b0}}, s1_x_q[MW-1:0]} * {{MW{1'b0}}, s1_m_q[MW-1:0]};
    prod_shift = prod_full >> FRAC;
    s2_sign_d  = s1_x_q[WIDTH-1] ^ s1_m_q[WIDTH-1];
    s2_mag_d   = (|prod_shift[2*MW-1:MW]) ? MAG_SAT : prod_shift[MW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q <= 1'b0;
    end else if (s2_free) begin
      s2_v_q <= s1_v_q;
    end
    if (s1_adv) begin
      s2_sign_q <= s2_sign_d;
      s2_mag_q  <= s2_mag_d;
      s2_c_q    <= s1_c_q;
    end
  end

  logic [MW:0]      mag_sum;
  logic             y_sign;
  logic [MW-1:0]    y_mag;
  logic [WIDTH-1:0] out_data_d;

  always_comb begin
    mag_sum = {1'b0, s2_mag_q} + {1'b0, s2_c_q[MW-1:0]};
    if (s2_sign_q == s2_c_q[WIDTH-1]) begin
      y_sign = s2_sign_q;
      y_mag  = mag_sum[MW] ? MAG_SAT : mag_sum[MW-1:0];
    end else if (s2_mag_q >= s2_c_q[MW-1:0]) begin
      y_sign = s2_sign_q;
      y_mag  = s2_mag_q - s2_c_q[MW-1:0];
    end else begin
      y_sign = s2_c_q[WIDTH-1];
      y_mag  = s2_c_q[MW-1:0] - s2_mag_q;
    end
    // Zero is always emitted as +0.
    out_data_d = {y_sign & (|y_mag), y_mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (s3_free) begin
        out_v_q <= s2_v_q;
      end
      if (s2_adv) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_v_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Self-checking bench for pwl_activation_pipe: directed scenarios plus a random phase,
// every output compared in order against an arithmetic reference model of y = m[k]*x + c[k].
module tb_pwl_activation_pipe;
  localparam int NSEG = 9;
  localparam int FRAC = 27;
  localparam logic [31:0] ONE  = 32'h0800_0000;
  localparam longint      MAXM = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwl_activation_pipe_if #(.WIDTH(32), .AW(4)) bus_if ();

  pwl_activation_pipe #(.WIDTH(32), .FRAC(FRAC), .NSEG(NSEG), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [31:0] y;
    longint      acc;
    bit          lat;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  exp_t        expq[$];
  logic [31:0] outs[$];
  logic [31:0] tm [NSEG];
  logic [31:0] tc [NSEG];
  logic [31:0] tbp [NSEG-1];
  bit          lat_mode;
  bit          saw_block;
  bit          last_acc;

  logic [31:0] sp_m [NSEG] = '{32'h0000_0000, 32'h0010_2E4F, 32'h0068_1A2C, 32'h01B6_4C3E,
                               32'h03FF_319D, 32'h0649_E6A1, 32'h0797_D3B1, 32'h07EF_C5C2,
                               32'h0800_0000};
  logic [31:0] sp_c [NSEG] = '{32'h0002_0000, 32'h0050_0000, 32'h0130_0000, 32'h0380_0000,
                               32'h05B1_9EB2, 32'h05A0_0000, 32'h0520_0000, 32'h0120_0000,
                               32'h0003_0000};
  logic [31:0] sp_b [NSEG-1] = '{32'h9800_0000, 32'h9000_0000, 32'h8800_0000, 32'h8400_0000,
                                 32'h0400_0000, 32'h0800_0000, 32'h1000_0000, 32'h1800_0000};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sm2i(input logic [31:0] v);
    longint mag;
    mag = longint'(v[30:0]);
    return v[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] i2sm(input longint v);
    longint mag;
    mag = (v < 0) ? -v : v;
    if (mag > MAXM) mag = MAXM;
    if (mag == 0) return 32'h0;
    return {(v < 0), mag[30:0]};
  endfunction

  function automatic logic [31:0] model_y(input logic [31:0] x);
    int k = 0;
    longint unsigned pm;
    longint p;
    for (int i = 0; i < NSEG - 1; i++) if (sm2i(x) > sm2i(tbp[i])) k++;
    pm = (longint'(x[30:0]) * longint'(tm[k][30:0])) >> FRAC;
    if (pm > MAXM) pm = MAXM;
    p = (x[31] ^ tm[k][31]) ? -longint'(pm) : longint'(pm);
    return i2sm(p + sm2i(tc[k]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSEG; i++) begin
      tm[i] = ONE;
      tc[i] = 32'h0;
    end
    for (int i = 0; i < NSEG - 1; i++) tbp[i] = 32'h7FFF_FFFF;
    expq.delete();
  endtask

  // Observe one cycle at the falling edge, then advance past the rising edge.
  task automatic tick();
    exp_t e;
    int a;
    @(negedge clk);
    cyc++;
    last_acc = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (bus_if.in_valid && !bus_if.in_ready && !bus_if.cfg_we) saw_block = 1'b1;
      if (bus_if.in_valid && bus_if.in_ready) begin
        last_acc = 1'b1;
        expq.push_back('{y: model_y(bus_if.in_data), acc: cyc, lat: lat_mode});
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (expq.size() == 0) begin
          check("out_valid_with_nothing_pending", bus_if.out_valid, 0);
        end else begin
          e = expq.pop_front();
          check("out_data", bus_if.out_data, e.y);
          if (e.lat) check("latency", cyc - e.acc, 3);
          outs.push_back(bus_if.out_data);
        end
      end
      if (bus_if.cfg_we) begin
        check("in_ready_during_cfg", bus_if.in_ready, 0);
        a = int'(bus_if.cfg_addr);
        case (bus_if.cfg_sel)
          2'd0: if (a < NSEG) tm[a] = bus_if.cfg_data;
          2'd1: if (a < NSEG) tc[a] = bus_if.cfg_data;
          2'd2: if (a < NSEG - 1) tbp[a] = bus_if.cfg_data;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x);
    int n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = x;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    bus_if.in_valid = 1'b0;
    check("send_accepted", last_acc, 1);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] addr, input logic [31:0] d);
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_sel  = sel;
    bus_if.cfg_addr = addr;
    bus_if.cfg_data = d;
    tick();
    bus_if.cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    while (expq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_complete", expq.size(), 0);
  endtask

  task automatic load_softplus();
    for (int i = 0; i < NSEG; i++) begin
      cfg(2'd0, 4'(i), sp_m[i]);
      cfg(2'd1, 4'(i), sp_c[i]);
    end
    for (int i = 0; i < NSEG - 1; i++) cfg(2'd2, 4'(i), sp_b[i]);
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31], 2'b00, 29'($urandom)};
  endfunction

  initial begin
    logic [31:0] xs[$];
    int idx;
    int n;

    rst = 1'b1;
    bus_if.cfg_we = 1'b0;
    bus_if.cfg_sel = 2'd0;
    bus_if.cfg_addr = 4'd0;
    bus_if.cfg_data = 32'h0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data = 32'h0;
    bus_if.out_ready = 1'b1;
    lat_mode = 1'b0;
    saw_block = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check("reset_out_valid", bus_if.out_valid, 0);
    check("reset_out_data", bus_if.out_data, 0);
    check("reset_in_ready", bus_if.in_ready, 1);

    // Identity table passes x through with latency 3.
    lat_mode = 1'b1;
    outs.delete();
    send(ONE);
    drain();
    check("identity_1p0", outs[0], ONE);

    // Softplus table: +0 and -0 both land in segment 4 and return c[4].
    load_softplus();
    outs.delete();
    send(32'h0000_0000);
    drain();
    send(32'h8000_0000);
    drain();
    check("softplus_x0", outs[0], 32'h05B1_9EB2);
    check("softplus_xneg0", outs[1], 32'h05B1_9EB2);

    // Back-to-back stream with out_ready toggling 1010.
    lat_mode = 1'b0;
    saw_block = 1'b0;
    outs.delete();
    for (int i = 0; i < 16; i++) xs.push_back(rand_x());
    idx = 0;
    n = 0;
    bus_if.in_valid = 1'b1;
    while (idx < 16 && n < 200) begin
      bus_if.in_data = xs[idx];
      bus_if.out_ready = (n % 2 == 0);
      tick();
      if (last_acc) idx++;
      n++;
    end
    bus_if.in_valid = 1'b0;
    check("stream_all_accepted", idx, 16);
    drain();
    check("stream_out_count", outs.size(), 16);
    check("stream_in_ready_dropped", saw_block, 1);

    // c[0] rewritten while a segment-0 sample is in S2.
    lat_mode = 1'b1;
    outs.delete();
    send(32'hA000_0000);
    tick();
    cfg(2'd1, 4'd0, 32'h0012_3456);
    send(32'hA000_0000);
    drain();
    check("cfg_old_c0", outs[0], 32'h0002_0000);
    check("cfg_new_c0", outs[1], 32'h0012_3456);

    // Saturation and signed cancellation on a fresh identity table.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NSEG; k++) cfg(2'd1, 4'(k), 32'h7FFF_FFFF);
    outs.delete();
    send(ONE);
    drain();
    for (int k = 0; k < NSEG; k++) cfg(2'd1, 4'(k), ONE);
    send(32'h8800_0000);
    drain();
    check("sat_max", outs[0], 32'h7FFF_FFFF);
    check("cancel_to_pos_zero", outs[1], 32'h0000_0000);

    // Reset with three samples in flight.
    bus_if.out_ready = 1'b0;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_if.in_data = 32'h0400_0000 + 32'(i);
      tick();
    end
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_out_valid", bus_if.out_valid, 0);
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_idle", bus_if.out_valid, 0);
    outs.delete();
    send(32'h0A00_0000);
    drain();
    check("post_rst_identity", outs[0], 32'h0A00_0000);

    // Out-of-range and ignored-select writes must leave the table alone.
    load_softplus();
    cfg(2'd0, 4'd9, 32'h1234_5678);
    cfg(2'd1, 4'd15, 32'h1234_5678);
    cfg(2'd2, 4'd8, 32'h8000_0001);
    cfg(2'd3, 4'd0, 32'h1234_5678);

    // Random traffic with sporadic table writes and backpressure.
    lat_mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus_if.in_valid  = ($urandom_range(0, 3) != 0);
      bus_if.in_data   = rand_x();
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      bus_if.cfg_we    = ($urandom_range(0, 15) == 0);
      bus_if.cfg_sel   = 2'($urandom_range(0, 3));
      bus_if.cfg_addr  = 4'($urandom_range(0, 15));
      bus_if.cfg_data  = rand_x();
      tick();
    end
    bus_if.cfg_we = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
